// File: rtl/cop0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cop0_pkg
//  Description : Shared constants and types for the system coprocessor 0:
//                register numbers, exception codes, Status/Cause bit
//                positions and the per-cycle event type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cop0_pkg;

    // COP0 register numbers (rd field of MTC0/MFC0)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status bit positions
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;

    // Cause bit positions
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI_BIT  = 30;
    localparam int CAUSE_BD_BIT  = 31;

    // The single state-changing action selected in a cycle, by priority
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_TRAP = 2'd1,   // exception or interrupt
        EV_ERET = 2'd2,
        EV_MTC0 = 2'd3
    } cop0_event_e;

    // Packs the Cause register fields into their architectural positions
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic       ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exc_code);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD_BIT]                       = bd;
        v[CAUSE_TI_BIT]                       = ti;
        v[CAUSE_IP_LSB +: 8]                  = ip;
        v[CAUSE_EXC_LSB +: 5]                 = exc_code;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cop0_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cop0_timer
//  Description : Count/Compare pair. Count free-runs and wraps; an MTC0 to
//                Count overrides the increment. TI latches when Count equals
//                Compare and is cleared only by a Compare write.
//  Revision    : 1.0 - initial release
// ============================================================================
module cop0_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Count: free-running increment with natural wrap, write takes precedence
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_count_we) begin
            r_count <= i_wdata;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

    // Compare and TI: the match uses pre-edge values; a Compare write wins over a match
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else if (i_compare_we) begin
            r_compare <= i_wdata;
            r_ti      <= 1'b0;
        end else if (r_count == r_compare) begin
            r_ti      <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cop0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cop0_unit
//  Description : System coprocessor 0. Holds Status, Cause, EPC and the
//                timer, arbitrates exceptions, interrupts, ERET and MTC0,
//                and issues a registered one-cycle PC redirect to fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module cop0_unit
    import cop0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mtc0,
    input  logic        i_mfc0,
    input  logic        i_eret,
    input  logic [4:0]  i_reg_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic        i_exc_valid,
    input  logic [4:0]  i_exc_code,
    input  logic [31:0] i_pc,
    input  logic        i_in_delay_slot,
    input  logic [5:0]  i_hw_int,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_exl
);

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exc_code;
    logic [1:0]  r_sw_ip;
    logic [31:0] r_epc;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [7:0]  w_ip;
    logic        w_int_pending;
    logic        w_wr;
    cop0_event_e w_event;

    // Hardware line 5 shares IP[7] with the timer
    assign w_ip          = {w_ti | i_hw_int[5], i_hw_int[4:0], r_sw_ip};
    assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));

    // Select the one action this cycle: exception/interrupt, then ERET, then MTC0
    always_comb begin
        w_event = EV_NONE;
        if (i_exc_valid || w_int_pending) begin
            w_event = EV_TRAP;
        end else if (i_eret) begin
            w_event = EV_ERET;
        end else if (i_mtc0) begin
            w_event = EV_MTC0;
        end
    end

    assign w_wr = (w_event == EV_MTC0);

    cop0_timer u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_count_we   (w_wr && (i_reg_addr == REG_COUNT)),
        .i_compare_we (w_wr && (i_reg_addr == REG_COMPARE)),
        .i_wdata      (i_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // Status/Cause/EPC update and the registered redirect pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_im          <= '0;
            r_exl         <= 1'b1;
            r_ie          <= 1'b0;
            r_bd          <= 1'b0;
            r_exc_code    <= '0;
            r_sw_ip       <= '0;
            r_epc         <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= 1'b0;
            case (w_event)
                EV_TRAP: begin
                    // A nested trap keeps the EPC/BD of the outermost one
                    if (!r_exl) begin
                        r_epc <= i_in_delay_slot ? (i_pc - 32'd4) : i_pc;
                        r_bd  <= i_in_delay_slot;
                    end
                    r_exl         <= 1'b1;
                    r_exc_code    <= i_exc_valid ? i_exc_code : EXC_INT;
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= EXC_VECTOR;
                end
                EV_ERET: begin
                    r_exl         <= 1'b0;
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= r_epc;
                end
                EV_MTC0: begin
                    case (i_reg_addr)
                        REG_STATUS: begin
                            r_im  <= i_wdata[STATUS_IM_LSB +: 8];
                            r_exl <= i_wdata[STATUS_EXL_BIT];
                            r_ie  <= i_wdata[STATUS_IE_BIT];
                        end
                        REG_CAUSE: r_sw_ip <= i_wdata[CAUSE_IP_LSB +: 2];
                        REG_EPC:   r_epc   <= i_wdata;
                        default:   ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // MFC0 read port: current register contents, zero when not reading
    always_comb begin
        o_rdata = '0;
        if (i_mfc0) begin
            case (i_reg_addr)
                REG_COUNT:   o_rdata = w_count;
                REG_COMPARE: o_rdata = w_compare;
                REG_STATUS:  o_rdata = {16'd0, r_im, 6'd0, r_exl, r_ie};
                REG_CAUSE:   o_rdata = pack_cause(r_bd, w_ti, w_ip, r_exc_code);
                REG_EPC:     o_rdata = r_epc;
                default:     o_rdata = '0;
            endcase
        end
    end

    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;
    assign o_exl         = r_exl;

endmodule
`default_nettype wire
